// File: rtl/cu_sequence_counter.sv
`default_nettype none
// ============================================================================
// cu_sequence_counter : CU control-step counter (clear/load/stall/halt)
// Rev 1.0
// ============================================================================
module cu_sequence_counter #(
  parameter int N      = 6,
  parameter int STATES = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic [N-1:0] ld_value,
  input  logic         en,
  input  logic         stall,
  input  logic         halt_req,
  input  logic         resume,
  output logic [N-1:0] counter_value,
  output logic         wrap,
  output logic         halted,
  output logic         load_err
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [N-1:0] C_LAST   = N'(STATES - 1);
  // One extra bit so STATES == 2**N still compares correctly.
  localparam logic [N:0]   C_STATES = (N + 1)'(STATES);

  state_t       r_state;
  logic [N-1:0] r_count;
  logic         r_wrap;
  logic         r_halted;
  logic         r_load_err;
  logic         w_ld_ok;

  assign w_ld_ok = ({1'b0, ld_value} < C_STATES);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_count    <= '0;
      r_wrap     <= 1'b0;
      r_halted   <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (clr) begin
            r_count    <= '0;
            r_load_err <= 1'b0;
          end else if (halt_req) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else if (ld) begin
            if (w_ld_ok) begin
              r_count <= ld_value;
            end else begin
              r_count    <= '0;
              r_load_err <= 1'b1;
            end
          end else if (en && !stall) begin
            if (r_count == C_LAST) begin
              r_count <= '0;
              r_wrap  <= 1'b1;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        ST_HALTED: begin
          if (clr) begin
            r_count    <= '0;
            r_load_err <= 1'b0;
          end
          if (resume) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign counter_value = r_count;
  assign wrap          = r_wrap;
  assign halted        = r_halted;
  assign load_err      = r_load_err;

endmodule
`default_nettype wire
